// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor; the master issues start/a/b
// and the slave returns busy/done and the registered result flags.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned a-b, LSB first; done pulses WIDTH cycles after the accepting edge.
// No backpressure: start is only honoured in IDLE, one operation per WIDTH+2 cycles.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  sif
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             zero_q;

  logic             d;
  logic             br_nxt;
  logic [WIDTH-1:0] res_nxt;
  logic             last_bit;

  // Full-subtractor on the current LSBs; result bits enter at the MSB so the
  // first-processed bit ends up at position 0 after WIDTH shifts.
  always_comb begin
    d        = sa[0] ^ sb[0] ^ br;
    br_nxt   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    res_nxt  = {d, res[WIDTH-1:1]};
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sa       <= '0;
      sb       <= '0;
      res      <= '0;
      br       <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sif.start) begin
            sa    <= sif.a;
            sb    <= sif.b;
            br    <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_nxt;
          res <= res_nxt;
          cnt <= cnt + CW'(1);
          if (last_bit) begin
            diff_q   <= res_nxt;
            borrow_q <= br_nxt;
            zero_q   <= (res_nxt == '0);
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign sif.busy   = (state == SHIFT) || (state == DONE);
  assign sif.done   = (state == DONE);
  assign sif.diff   = diff_q;
  assign sif.borrow = borrow_q;
  assign sif.zero   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): latency, results, start
// blocking while busy, mid-operation reset and back-to-back operation.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  serial_subtractor_if #(.WIDTH(WIDTH)) sif ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // k=0 is the accepting edge; samples are taken 1 time unit after each edge.
  task automatic observe(input int ncyc, output int done_at, output int ndone,
                         output int nbusy, output logic [31:0] d_diff,
                         output logic [31:0] d_borrow, output logic [31:0] d_zero);
    done_at  = -1;
    ndone    = 0;
    nbusy    = 0;
    d_diff   = '1;
    d_borrow = '1;
    d_zero   = '1;
    for (int k = 0; k < ncyc; k++) begin
      tick();
      if (k == 0) sif.start = 1'b0;
      if (sif.busy) nbusy++;
      if (sif.done) begin
        ndone++;
        if (done_at < 0) begin
          done_at  = k;
          d_diff   = 32'(sif.diff);
          d_borrow = 32'(sif.borrow);
          d_zero   = 32'(sif.zero);
        end
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input int e_diff, input int e_borrow, input int e_zero);
    int done_at, ndone, nbusy;
    logic [31:0] dd, db, dz;
    sif.start = 1'b1;
    sif.a     = a;
    sif.b     = b;
    observe(10, done_at, ndone, nbusy, dd, db, dz);
    check({tag, " done_at"}, 32'(done_at), 32'd8);
    check({tag, " ndone"},   32'(ndone),   32'd1);
    check({tag, " nbusy"},   32'(nbusy),   32'd9);
    check({tag, " diff"},    dd, 32'(e_diff));
    check({tag, " borrow"},  db, 32'(e_borrow));
    check({tag, " zero"},    dz, 32'(e_zero));
    check({tag, " diff_hold"}, 32'(sif.diff), 32'(e_diff));
  endtask

  initial begin
    int done_at, ndone, nbusy, bad;
    logic [31:0] dd, db, dz;
    total     = 0;
    passed    = 0;
    rst_n     = 1'b0;
    sif.start = 1'b0;
    sif.a     = '0;
    sif.b     = '0;

    repeat (3) tick();
    check("rst busy",   32'(sif.busy),   32'd0);
    check("rst done",   32'(sif.done),   32'd0);
    check("rst diff",   32'(sif.diff),   32'd0);
    check("rst borrow", 32'(sif.borrow), 32'd0);
    check("rst zero",   32'(sif.zero),   32'd0);
    rst_n = 1'b1;

    run_op("10-5",    8'd10,  8'd5,   5,   0, 0);
    run_op("0-1",     8'd0,   8'd1,   255, 1, 0);
    run_op("128-255", 8'd128, 8'd255, 129, 1, 0);
    run_op("200-200", 8'd200, 8'd200, 0,   0, 1);
    run_op("255-0",   8'd255, 8'd0,   255, 0, 0);

    // start held high with new operands while the first operation runs
    sif.start = 1'b1;
    sif.a     = 8'd10;
    sif.b     = 8'd5;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) begin
        sif.a = 8'd1;
        sif.b = 8'd2;
        ndone = 0;
        dd    = '1;
      end
      if (sif.done) begin
        ndone++;
        dd = 32'(sif.diff);
        check("hold done_at", 32'(k), 32'd8);
      end
    end
    check("hold ndone",      32'(ndone),     32'd1);
    check("hold diff",       dd,             32'd5);
    check("hold idle_busy",  32'(sif.busy),  32'd0);
    check("hold diff_after", 32'(sif.diff),  32'd5);
    observe(10, done_at, ndone, nbusy, dd, db, dz);
    check("next done_at", 32'(done_at), 32'd8);
    check("next diff",    dd,           32'd255);
    check("next borrow",  db,           32'd1);

    // reset partway through the bit loop
    sif.start = 1'b1;
    sif.a     = 8'd100;
    sif.b     = 8'd50;
    tick();
    sif.start = 1'b0;
    repeat (4) tick();
    check("abort busy_pre", 32'(sif.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy",   32'(sif.busy),   32'd0);
    check("abort diff",   32'(sif.diff),   32'd0);
    check("abort borrow", 32'(sif.borrow), 32'd0);
    ndone = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (sif.done) ndone++;
    end
    check("abort no_done", 32'(ndone), 32'd0);
    rst_n = 1'b1;
    run_op("100-50", 8'd100, 8'd50, 50, 0, 0);

    // continuous start: one result every 10 cycles
    sif.start = 1'b1;
    sif.a     = 8'd7;
    sif.b     = 8'd3;
    ndone     = 0;
    bad       = 0;
    done_at   = -1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (sif.done) begin
        ndone++;
        if (done_at < 0) done_at = k;
        if ((k % 10) != 8 || sif.diff != 8'd4) bad++;
      end
    end
    sif.start = 1'b0;
    check("b2b first", 32'(done_at), 32'd8);
    check("b2b ndone", 32'(ndone),   32'd3);
    check("b2b bad",   32'(bad),     32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, the operation request, sampled on a rising clk edge.
REQ-005 The block SHALL have port a, input, WIDTH, the unsigned minuend, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH, the unsigned subtrahend, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1, a single-cycle completion pulse.
REQ-009 The block SHALL have port diff, output, WIDTH, the result (a - b) mod 2^WIDTH.
REQ-010 The block SHALL have port borrow, output, 1, set to 1 when a < b (unsigned).
REQ-011 The block SHALL have port zero, output, 1, set to 1 when diff == 0.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1 at an edge (edge 0), the block SHALL latch a and b into shift registers, clear its internal borrow bit, clear the bit counter, and go to SHIFT.
REQ-014 In SHIFT, the block SHALL process one bit per edge, LSB first, at edges 1..WIDTH: d = a_i ^ b_i ^ br, and br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-015 The block SHALL shift each result bit into an internal result register, MSB-in, so the register holds diff LSB-aligned after WIDTH bits.
REQ-016 At edge WIDTH, the block SHALL load diff, borrow (final br) and zero together, and go to DONE.
REQ-017 done SHALL be 1 only while in DONE, exactly one cycle, in the cycle following edge WIDTH.
REQ-018 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-019 Latency from the start-accepting edge to the done cycle SHALL be WIDTH cycles, with a throughput of one operation per WIDTH+2 cycles.
REQ-020 busy SHALL be 1 in SHIFT and in DONE, and 0 in IDLE.
REQ-021 start SHALL be ignored when not in IDLE; no re-capture, no restart and no effect on the running result.
REQ-022 a and b SHALL be don't-care except at the accepting edge; changes during SHIFT SHALL NOT affect the result.
REQ-023 diff, borrow and zero SHALL change only at the completion edge and SHALL hold their values until the next completion.
REQ-024 Wrap-around: results SHALL be modulo 2^WIDTH with no saturation, and borrow SHALL be the only underflow indication.
REQ-025 a == b SHALL give diff=0, zero=1 and borrow=0.
REQ-026 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide, and SHALL NOT wrap within an operation.

Reset
REQ-027 rst_n=0 SHALL asynchronously force the FSM to IDLE and clear the counter, shift registers and internal borrow bit.
REQ-028 On reset, the outputs SHALL be busy=0, done=0, diff=0, borrow=0 and zero=0.
REQ-029 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no done pulse, and the outputs SHALL take their reset values.
REQ-030 After rst_n deasserts, the first edge SHALL see the block in IDLE, able to accept start on that edge.

Verification
REQ-031 The bench SHALL cover: a=10, b=5, start one cycle -> done pulse 8 cycles after the accepting edge, diff=5, borrow=0, zero=0, busy high for 9 cycles.
REQ-032 The bench SHALL cover: a=0, b=1 -> diff=255, borrow=1, zero=0; and a=128, b=255 -> diff=129, borrow=1.
REQ-033 The bench SHALL cover: a=200, b=200 -> diff=0, zero=1, borrow=0; and a=255, b=0 -> diff=255, borrow=0.
REQ-034 The bench SHALL cover: a=10, b=5 started, then start held high with a=1, b=2 during SHIFT -> result 5 unchanged, a single done pulse, next operation accepted only after return to IDLE.
REQ-035 The bench SHALL cover: rst_n pulsed low at bit 4 of a=100, b=50 operation -> busy=0, diff=0 immediately, no done; a new a=100, b=50 operation -> diff=50.
REQ-036 The bench SHALL cover: back-to-back starts (start held high continuously) -> results at every 10 cycles, each done exactly one cycle wide.
